// File: rtl/adder_tree_pkg.sv
// Shared definitions for adder_tree and its stream feeder: result/count width
// derivations and the default-sized tree input vector type.
package adder_tree_pkg;

  localparam int unsigned DEF_DATAWIDTH  = 4;
  localparam int unsigned DEF_NUM_INPUTS = 16;

  // Tree result width: six guard bits cover up to 32 summed lanes plus margin.
  function automatic int unsigned sum_w(input int unsigned datawidth);
    return datawidth + 6;
  endfunction

  // Frame sample count width: must hold NUM_INPUTS itself, not just an index.
  function automatic int unsigned cnt_w(input int unsigned num_inputs);
    return $clog2(num_inputs) + 1;
  endfunction

  typedef logic [DEF_DATAWIDTH-1:0] tree_vec_t [DEF_NUM_INPUTS];

endpackage

// File: rtl/adder_tree_feeder_if.sv
// Stream-in, tree-side and result-out signals of adder_tree_feeder.
// The feeder itself connects through the slave modport.
interface adder_tree_feeder_if
  import adder_tree_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = DEF_DATAWIDTH,
  parameter int unsigned NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int unsigned SUM_W      = sum_w(DATAWIDTH),
  parameter int unsigned CNT_W      = cnt_w(NUM_INPUTS)
);

  logic                 s_valid;
  logic                 s_ready;
  logic [DATAWIDTH-1:0] s_data;
  logic                 s_last;

  logic                 tree_valid;
  logic [DATAWIDTH-1:0] tree_data [NUM_INPUTS];
  logic                 tree_res_valid;
  logic [SUM_W-1:0]     tree_res_sum;

  logic                 m_valid;
  logic                 m_ready;
  logic [SUM_W-1:0]     m_sum;
  logic [CNT_W-1:0]     m_count;

  modport slave (
    input  s_valid, s_data, s_last, tree_res_valid, tree_res_sum, m_ready,
    output s_ready, tree_valid, tree_data, m_valid, m_sum, m_count
  );

  modport master (
    output s_valid, s_data, s_last, tree_res_valid, tree_res_sum, m_ready,
    input  s_ready, tree_valid, tree_data, m_valid, m_sum, m_count
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with async active-low reset; a push on a full FIFO is
// accepted only when a pop happens in the same cycle. Read data is 0 when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/adder_tree_feeder.sv
// Packs a sample stream into zero-padded adder_tree input frames and collects
// the in-order tree results; credits bound frames in flight to the result FIFO depth.
module adder_tree_feeder
  import adder_tree_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = DEF_DATAWIDTH,
  parameter int unsigned NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int unsigned RES_DEPTH  = 4,
  parameter int unsigned SUM_W      = sum_w(DATAWIDTH),
  parameter int unsigned CNT_W      = cnt_w(NUM_INPUTS)
) (
  input  logic                clk,
  input  logic                rst,
  adder_tree_feeder_if.slave  bus,
  output logic                res_err
);

  localparam int unsigned IDX_W = CNT_W - 1;
  localparam int unsigned RSV_W = $clog2(RES_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  logic [DATAWIDTH-1:0] r_lane      [NUM_INPUTS];
  logic [DATAWIDTH-1:0] r_tree_data [NUM_INPUTS];
  logic [IDX_W-1:0]     r_idx;
  logic                 r_tree_valid;
  logic [RSV_W-1:0]     r_reserved;
  logic [RSV_W-1:0]     r_pending;
  logic                 r_res_err;

  logic                 w_accept;
  logic                 w_complete;
  logic                 w_pop;
  logic                 w_release;
  logic                 w_res_expected;
  logic                 w_res_ok;
  logic                 w_bad_res;
  logic [CNT_W-1:0]     w_count;
  logic                 w_cnt_empty;
  logic                 w_cnt_full;
  logic                 w_res_empty;
  logic                 w_res_full;

  assign bus.s_ready = rst && (r_reserved < RSV_W'(RES_DEPTH)) && !w_cnt_full;
  assign w_accept    = bus.s_valid && bus.s_ready;
  assign w_complete  = w_accept && ((r_idx == LAST_IDX) || bus.s_last);
  assign w_count     = {1'b0, r_idx} + CNT_W'(1);

  assign bus.m_valid = !w_res_empty;
  assign w_pop       = bus.m_valid && bus.m_ready;
  assign w_release   = w_pop && !w_cnt_empty;

  // A result is legitimate only while some issued frame is still inside the tree.
  assign w_res_expected = (r_pending != '0) || r_tree_valid;
  assign w_res_ok       = bus.tree_res_valid && w_res_expected;
  assign w_bad_res      = bus.tree_res_valid && ((w_res_full && !w_pop) || !w_res_expected);

  assign bus.tree_valid = r_tree_valid;
  assign bus.tree_data  = r_tree_data;
  assign res_err        = r_res_err;

  // Lanes above the current index are always 0, so the copy needs no extra masking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx        <= '0;
      r_tree_valid <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        r_lane[i]      <= '0;
        r_tree_data[i] <= '0;
      end
    end else begin
      r_tree_valid <= w_complete;
      if (w_complete) begin
        r_idx <= '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
          r_tree_data[i] <= (IDX_W'(i) == r_idx) ? bus.s_data : r_lane[i];
          r_lane[i]      <= '0;
        end
      end else if (w_accept) begin
        r_lane[r_idx] <= bus.s_data;
        r_idx         <= r_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reserved <= '0;
      r_pending  <= '0;
      r_res_err  <= 1'b0;
    end else begin
      case ({w_complete, w_release})
        2'b10:   r_reserved <= r_reserved + 1'b1;
        2'b01:   r_reserved <= r_reserved - 1'b1;
        default: ;
      endcase
      case ({r_tree_valid, w_res_ok})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: ;
      endcase
      if (w_bad_res) r_res_err <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (RES_DEPTH)
  ) u_cnt_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_complete),
    .i_wdata (w_count),
    .i_pop   (w_pop),
    .o_rdata (bus.m_count),
    .o_empty (w_cnt_empty),
    .o_full  (w_cnt_full)
  );

  sync_fifo #(
    .WIDTH (SUM_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.tree_res_valid),
    .i_wdata (bus.tree_res_sum),
    .i_pop   (w_pop),
    .o_rdata (bus.m_sum),
    .o_empty (w_res_empty),
    .o_full  (w_res_full)
  );

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Directed and randomized bench for adder_tree_feeder with a behavioural
// fixed-latency adder tree and a result scoreboard.
module tb_adder_tree_feeder;
  import adder_tree_pkg::*;

  localparam int unsigned DW  = 4;
  localparam int unsigned NI  = 16;
  localparam int unsigned RD  = 4;
  localparam int unsigned SW  = sum_w(DW);
  localparam int unsigned CW  = cnt_w(NI);
  localparam int          LAT = 3;

  typedef struct packed {
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic res_err;

  logic          mdl_valid = 1'b0;
  logic [SW-1:0] mdl_sum   = '0;
  logic          inj       = 1'b0;

  int n_cmp   = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int n_issue = 0;
  int mr_mode = 0;
  bit s_fire  = 1'b0;

  exp_t              sb_q[$];
  logic [NI*DW-1:0]  lane_q[$];
  logic [SW-1:0]     mdl_sum_q[$];
  int                mdl_due_q[$];

  always #5 clk = ~clk;

  adder_tree_feeder_if #(
    .DATAWIDTH  (DW),
    .NUM_INPUTS (NI),
    .SUM_W      (SW),
    .CNT_W      (CW)
  ) bus ();

  assign bus.tree_res_valid = mdl_valid | inj;
  assign bus.tree_res_sum   = mdl_sum;

  adder_tree_feeder #(
    .DATAWIDTH  (DW),
    .NUM_INPUTS (NI),
    .RES_DEPTH  (RD),
    .SUM_W      (SW),
    .CNT_W      (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .res_err (res_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NI*DW-1:0] pack_bus();
    logic [NI*DW-1:0] p = '0;
    for (int i = 0; i < NI; i++) p[i*DW +: DW] = bus.tree_data[i];
    return p;
  endfunction

  // One clock: observe at negedge (tree model, scoreboard), return at posedge+1.
  task automatic cycle();
    exp_t e;
    int   s;
    @(negedge clk);
    mdl_valid = 1'b0;
    mdl_sum   = '0;
    if (mdl_due_q.size() > 0 && mdl_due_q[0] <= cyc) begin
      mdl_valid = 1'b1;
      mdl_sum   = mdl_sum_q.pop_front();
      void'(mdl_due_q.pop_front());
    end
    if (bus.tree_valid === 1'b1) begin
      n_issue++;
      s = 0;
      for (int i = 0; i < NI; i++) s += int'(bus.tree_data[i]);
      mdl_sum_q.push_back(SW'(s));
      mdl_due_q.push_back(cyc + LAT);
      chk("issue expected", 64'(lane_q.size() > 0), 64'd1);
      if (lane_q.size() > 0) chk("tree_data", pack_bus(), lane_q.pop_front());
    end
    if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      chk("pop expected", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("m_sum", 64'(bus.m_sum), 64'(e.sum));
        chk("m_count", 64'(bus.m_count), 64'(e.cnt));
      end
    end
    s_fire = bus.s_valid && bus.s_ready;
    cyc++;
    @(posedge clk);
    #1;
    case (mr_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'b1;
      2:       bus.m_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic send_sample(input logic [DW-1:0] d, input bit last, input bit thr);
    int guard = 0;
    bus.s_data = d;
    bus.s_last = last;
    do begin
      bus.s_valid = thr ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle();
      guard++;
    end while (!s_fire && guard < 3000);
    bus.s_valid = 1'b0;
    if (!s_fire) begin
      chk("s handshake timeout", 64'(s_fire), 64'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "stream input stalled");
    end
  endtask

  task automatic send_frame(input int len, input int vals[NI], input bit last_full, input bit thr);
    tree_vec_t        v;
    logic [NI*DW-1:0] p = '0;
    int               s = 0;
    exp_t             e;
    for (int i = 0; i < NI; i++) begin
      v[i] = (i < len) ? DW'(vals[i]) : '0;
      p[i*DW +: DW] = v[i];
      s += int'(v[i]);
    end
    e.sum = SW'(s);
    e.cnt = CW'(len);
    sb_q.push_back(e);
    lane_q.push_back(p);
    for (int i = 0; i < len; i++)
      send_sample(v[i], (i == len - 1) && (len < NI || last_full), thr);
  endtask

  task automatic drain(input int budget);
    mr_mode = 1;
    for (int k = 0; k < budget && (sb_q.size() > 0 || lane_q.size() > 0); k++) cycle();
    chk("drained scoreboard", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    mdl_valid   = 1'b0;
    mdl_sum_q.delete();
    mdl_due_q.delete();
    #1;
    chk("rst s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst tree_valid", 64'(bus.tree_valid), 64'd0);
    chk("rst tree_data", pack_bus(), 64'd0);
    chk("rst m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst m_sum", 64'(bus.m_sum), 64'd0);
    chk("rst m_count", 64'(bus.m_count), 64'd0);
    chk("rst res_err", 64'(res_err), 64'd0);
    repeat (2) cycle();
    rst = 1'b1;
    #1;
    chk("s_ready after reset", 64'(bus.s_ready), 64'd1);
  endtask

  initial begin
    int fv[NI];
    int n0;
    int nf;
    int len;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    do_reset();

    // 16 ones, s_last on the 16th sample
    mr_mode = 1;
    n0 = n_issue;
    for (int i = 0; i < NI; i++) fv[i] = 1;
    send_frame(16, fv, 1'b1, 1'b0);
    drain(50);
    chk("one issue per frame", 64'(n_issue - n0), 64'd1);

    // short frames: padding and single-sample frame
    fv = '{default: 0};
    fv[0] = 5; fv[1] = 6; fv[2] = 7;
    send_frame(3, fv, 1'b0, 1'b0);
    fv[0] = 9;
    send_frame(1, fv, 1'b0, 1'b0);
    drain(50);

    // credit stall: four full frames with no pops
    mr_mode = 0;
    for (int i = 0; i < NI; i++) fv[i] = i;
    n0 = n_issue;
    repeat (RD) send_frame(16, fv, 1'b0, 1'b0);
    chk("s_ready stalled", 64'(bus.s_ready), 64'd0);
    nf = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = 4'd2;
    repeat (10) begin
      cycle();
      nf += int'(s_fire);
    end
    bus.s_valid = 1'b0;
    chk("no accept while stalled", 64'(nf), 64'd0);
    chk("issued frames at stall", 64'(n_issue - n0), 64'(RD));
    chk("m_valid while stalled", 64'(bus.m_valid), 64'd1);
    mr_mode = 3;
    bus.m_ready = 1'b1;
    cycle();
    bus.m_ready = 1'b0;
    chk("s_ready after one pop", 64'(bus.s_ready), 64'd1);
    chk("entries left after pop", 64'(sb_q.size()), 64'(RD - 1));
    drain(50);

    // spurious tree result
    mr_mode = 0;
    repeat (LAT + 2) cycle();
    chk("res_err before inject", 64'(res_err), 64'd0);
    inj = 1'b1;
    cycle();
    inj = 1'b0;
    chk("res_err set", 64'(res_err), 64'd1);
    repeat (5) cycle();
    chk("res_err sticky", 64'(res_err), 64'd1);

    // reset in the middle of a frame
    do_reset();
    for (int i = 0; i < 7; i++) send_sample(DW'(i + 1), 1'b0, 1'b0);
    n0 = n_issue;
    do_reset();
    repeat (3) cycle();
    chk("no issue after mid-frame reset", 64'(n_issue - n0), 64'd0);
    fv = '{default: 0};
    fv[0] = 3; fv[1] = 4;
    mr_mode = 1;
    send_frame(2, fv, 1'b0, 1'b0);
    drain(50);

    // random throttling on both sides
    mr_mode = 2;
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, NI);
      for (int i = 0; i < NI; i++) fv[i] = $urandom_range(0, (1 << DW) - 1);
      send_frame(len, fv, 1'($urandom_range(0, 1)), 1'b1);
    end
    drain(500);
    chk("tree_data queue empty", 64'(lane_q.size()), 64'd0);
    chk("res_err after random", 64'(res_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_tree_feeder.md
# adder_tree_feeder

Stream-side front end and result collector for `adder_tree`. It packs a serial ready/valid sample stream into one `NUM_INPUTS`-lane vector per frame, zero-padding short frames terminated by `s_last`. It issues each vector to the tree as a single-cycle valid, then captures the in-order tree results into a small FIFO with a downstream ready/valid port. A credit counter guarantees that every issued frame has a free result slot, so the non-backpressurable tree can never overflow it.

## Interface
- `DATAWIDTH`, 4: sample width; equals the tree's `DATAWIDTH`.
- `NUM_INPUTS`, 16: lanes per frame, 2..32; equals the tree's `NUM_INPUTS`.
- `RES_DEPTH`, 4: result FIFO depth; also the maximum number of frames in flight.
- `SUM_W`, `DATAWIDTH+6`: tree result width.
- `CNT_W`, `$clog2(NUM_INPUTS)+1`: width of the frame sample count.

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: asynchronous, active-low reset.
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in `DATAWIDTH` / `s_last` in 1: sample stream input.
- `tree_valid` out 1: single-cycle issue strobe, connects to the tree's `i_valid`.
- `tree_data` out `DATAWIDTH` x [0:`NUM_INPUTS`-1]: connects to the tree's `in_data`.
- `tree_res_valid` in 1 / `tree_res_sum` in `SUM_W`: from the tree's `o_valid` / `sum_reg`.
- `m_valid` out 1 / `m_ready` in 1 / `m_sum` out `SUM_W` / `m_count` out `CNT_W`: result stream output.
- `res_err` out 1: sticky protocol-error flag.

## Operation
- A sample is accepted when `s_valid && s_ready`. It is written to collector lane `idx`, where `idx` counts 0..`NUM_INPUTS`-1.
- A frame completes when the accepted sample has `idx==NUM_INPUTS-1` or `s_last==1`.
- On completion, in the same edge:
  - Copy the collector, with the final sample merged in, into the `tree_data` register. Lanes above the final `idx` are 0.
  - Clear the collector and set `idx` to 0.
  - Push `idx+1` into the count FIFO.
  - Increment `reserved`.
- `tree_data` holds its value between issues. `tree_valid` is high for exactly one cycle per frame.
- `reserved` counts frames completed but not yet popped from the `m` side. It increments on completion and decrements on `m_valid && m_ready`; both in the same cycle leave it unchanged.
- `s_ready = rst && (reserved < RES_DEPTH)`. This is combinational from registers and has no dependency on `s_valid`.
- When `tree_res_valid` is high, push `tree_res_sum` into the result FIFO.
- `m_valid` means the result FIFO is not empty. `m_sum` and `m_count` come from the FIFO heads. A pop removes one entry from both FIFOs.
- `res_err` is set when `tree_res_valid` is high and either the result FIFO is full, or the count of results received exceeds the count of frames issued. It clears only on reset.
- A `s_last` on the first sample of a frame gives a 1-sample frame. A `s_last` at `idx==NUM_INPUTS-1` gives a normal full frame.
- Back-to-back full frames are accepted at one sample per cycle with no bubble while credits remain.

## Timing
- Reset values: `s_ready`=0 while `rst` is low, `tree_valid`=0, `tree_data` all zero, `m_valid`=0, `m_sum`=0, `m_count`=0, `res_err`=0, `idx`=0, `reserved`=0, both FIFOs empty.
- Final sample accepted at edge t → `tree_valid`=1 during cycle t+1.
- `tree_res_valid` at edge r → `m_valid`=1 from cycle r+1 if the FIFO was empty. There is no combinational path from `tree_res_*` to `m_*`.
- Credit stall: with `reserved==RES_DEPTH`, `s_ready` is 0. A pop at edge p makes `s_ready`=1 in cycle p+1.
- A pop and a push in the same cycle on a full FIFO is legal and keeps it full. Credits make this the only full-FIFO push case.
- Reset mid-frame: the partial frame is discarded and nothing is issued. The tree shares `rst`, so no stale results return.

## Structure
- Package `adder_tree_pkg`: `SUM_W`/`CNT_W` derivation functions and the `tree_vec_t` unpacked-vector typedef. `adder_tree` reuses the same package.
- One sub-module, `sync_fifo` (params `WIDTH`, `DEPTH`), instantiated twice: count FIFO (`CNT_W`) and result FIFO (`SUM_W`). Both have an async active-low reset.
- The top level holds the collector lanes, `idx`, the output register, `reserved` and `res_err`.

## Test plan
- 16 samples of value 1, `s_last` on the 16th, with an `adder_tree` attached → one `tree_valid` pulse, `m_sum`=16, `m_count`=16.
- 3-sample frame {5,6,7} with `s_last` on the third → lanes 3..15 are 0, `m_sum`=18, `m_count`=3. Also a 1-sample frame {9} → `m_sum`=9, `m_count`=1.
- `m_ready`=0, `RES_DEPTH`=4, continuous input → exactly 4 frames issued, then `s_ready`=0. Raise `m_ready` for one cycle → one pop, and `s_ready`=1 the next cycle.
- Inject `tree_res_valid` with no frame issued → `res_err`=1, and it stays set until reset.
- Assert `rst` after 7 samples of a frame → no `tree_valid`. After release, a fresh 2-sample frame {3,4} gives `m_sum`=7, `m_count`=2.
- Random `s_valid`/`m_ready` throttling over 1000 frames → `m_sum` and `m_count` match the model, in order, with `res_err`=0.
